// File: rtl/cpu_bus_arbiter.sv
// Two-port round-robin arbiter sharing one CPU bus between instruction fetch (A)
// and memory stage (B), with an optional bus-wait timeout.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic        o_pa_ready,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic        o_pb_ready,
  output logic [31:0] o_pb_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_timeout,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic [15:0] wait_q, wait_d;

  logic        own_a, own_b;
  logic        own_req, own_rw;
  logic [31:0] own_addr, own_wdata;
  logic        timeout_hit;

  // Bus side is a pure mux of the owner's request; reset blanks it immediately
  // so a ready arriving in the reset cycle is never forwarded.
  always_comb begin
    own_a     = (state_q == GRANT_A) && !i_reset;
    own_b     = (state_q == GRANT_B) && !i_reset;
    own_req   = 1'b0;
    own_rw    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    if (own_a) begin
      own_req   = i_pa_request;
      own_rw    = i_pa_rw;
      own_addr  = i_pa_address;
      own_wdata = i_pa_wdata;
    end else if (own_b) begin
      own_req   = i_pb_request;
      own_rw    = i_pb_rw;
      own_addr  = i_pb_address;
      own_wdata = i_pb_wdata;
    end
    timeout_hit = (TIMEOUT != 0) && own_req && !i_bus_ready &&
                  (wait_q == 16'(TIMEOUT));

    o_bus_request = own_req && !timeout_hit;
    o_bus_rw      = own_rw;
    o_bus_address = own_addr;
    o_bus_wdata   = own_wdata;
    o_pa_ready    = own_a && i_pa_request && (i_bus_ready || timeout_hit);
    o_pb_ready    = own_b && i_pb_request && (i_bus_ready || timeout_hit);
    o_pa_rdata    = i_bus_rdata;
    o_pb_rdata    = i_bus_rdata;
    o_timeout     = timeout_hit;
    o_grant       = {own_b, own_a};
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_d       = wait_q;
    case (state_q)
      IDLE: begin
        if (i_pa_request && i_pb_request) begin
          state_d      = last_grant_q ? GRANT_A : GRANT_B;
          last_grant_d = !last_grant_q;
          wait_d       = '0;
        end else if (i_pa_request) begin
          state_d      = GRANT_A;
          last_grant_d = 1'b0;
          wait_d       = '0;
        end else if (i_pb_request) begin
          state_d      = GRANT_B;
          last_grant_d = 1'b1;
          wait_d       = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (!own_req || i_bus_ready || timeout_hit) state_d = IDLE;
        else wait_d = wait_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a transaction-level model.
module tb_cpu_bus_arbiter;

  localparam int TMO = 4;

  logic        i_clock, i_reset;
  logic        i_pa_request, i_pa_rw, i_pb_request, i_pb_rw;
  logic [31:0] i_pa_address, i_pa_wdata, i_pb_address, i_pb_wdata;
  logic        o_pa_ready, o_pb_ready;
  logic [31:0] o_pa_rdata, o_pb_rdata;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_timeout;
  logic [1:0]  o_grant;

  cpu_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_pa_request(i_pa_request), .i_pa_rw(i_pa_rw),
    .i_pa_address(i_pa_address), .i_pa_wdata(i_pa_wdata),
    .o_pa_ready(o_pa_ready), .o_pa_rdata(o_pa_rdata),
    .i_pb_request(i_pb_request), .i_pb_rw(i_pb_rw),
    .i_pb_address(i_pb_address), .i_pb_wdata(i_pb_wdata),
    .o_pb_ready(o_pb_ready), .o_pb_rdata(o_pb_rdata),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_timeout(o_timeout), .o_grant(o_grant)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic drive(input logic rst, input logic a, input logic b, input logic rdy);
    i_reset = rst; i_pa_request = a; i_pb_request = b; i_bus_ready = rdy;
    #1;
  endtask

  // Field order: rst a b rdy | grant[1:0] pa_rdy pb_rdy timeout bus_req
  typedef struct packed {
    logic       rst, a, b, rdy;
    logic [1:0] grant;
    logic       pa_rdy, pb_rdy, to, breq;
  } vec_t;

  vec_t tbl[16];

  // Transaction-level reference: owner 0 = none, 1 = A, 2 = B
  int   m_owner, m_last, m_wait;
  logic done_a, done_b;

  task automatic model_step();
    int          own;
    logic        req, rw, to;
    logic [31:0] ad, wd;
    logic [1:0]  g;
    own = i_reset ? 0 : m_owner;
    req = 1'b0; rw = 1'b0; ad = '0; wd = '0; g = 2'b00;
    if (own == 1) begin req = i_pa_request; rw = i_pa_rw; ad = i_pa_address; wd = i_pa_wdata; g = 2'b01; end
    if (own == 2) begin req = i_pb_request; rw = i_pb_rw; ad = i_pb_address; wd = i_pb_wdata; g = 2'b10; end
    to = (own != 0) && req && !i_bus_ready && (m_wait == TMO);
    done_a = (own == 1) && i_pa_request && (i_bus_ready || to);
    done_b = (own == 2) && i_pb_request && (i_bus_ready || to);
    chk1("rnd_bus_req", o_bus_request, req && !to);
    chk1("rnd_bus_rw", o_bus_rw, rw);
    chk32("rnd_bus_addr", o_bus_address, ad);
    chk32("rnd_bus_wdata", o_bus_wdata, wd);
    chk1("rnd_pa_ready", o_pa_ready, done_a);
    chk1("rnd_pb_ready", o_pb_ready, done_b);
    chk1("rnd_timeout", o_timeout, to);
    chk32("rnd_grant", 32'(o_grant), 32'(g));
    chk32("rnd_pa_rdata", o_pa_rdata, i_bus_rdata);
    chk32("rnd_pb_rdata", o_pb_rdata, i_bus_rdata);
    if (i_reset) begin
      m_owner = 0; m_last = 1; m_wait = 0;
    end else if (m_owner == 0) begin
      if (i_pa_request && i_pb_request) m_owner = (m_last == 1) ? 2 : 1;
      else if (i_pa_request) m_owner = 1;
      else if (i_pb_request) m_owner = 2;
      if (m_owner != 0) begin m_last = m_owner; m_wait = 0; end
    end else if (!req || i_bus_ready || to) begin
      m_owner = 0;
    end else begin
      m_wait++;
    end
  endtask

  initial begin
    tbl[0]  = 10'b1111_00_0000;
    tbl[1]  = 10'b0110_00_0000;
    tbl[2]  = 10'b0110_10_0001;
    tbl[3]  = 10'b0111_10_0101;
    tbl[4]  = 10'b0111_00_0000;
    tbl[5]  = 10'b0101_01_1001;
    tbl[6]  = 10'b0000_00_0000;
    tbl[7]  = 10'b0100_00_0000;
    tbl[8]  = 10'b0001_01_0000;
    tbl[9]  = 10'b0010_00_0000;
    tbl[10] = 10'b0010_10_0001;
    tbl[11] = 10'b0010_10_0001;
    tbl[12] = 10'b0010_10_0001;
    tbl[13] = 10'b0010_10_0001;
    tbl[14] = 10'b0010_10_0110;
    tbl[15] = 10'b0000_00_0000;

    i_pa_rw = 1'b0; i_pa_address = 32'h100;  i_pa_wdata = 32'h11111111;
    i_pb_rw = 1'b1; i_pb_address = 32'h2000; i_pb_wdata = 32'h12345678;
    i_bus_rdata = '0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge i_clock);
    tick();

    // Directed table
    for (int unsigned r = 0; r < 16; r++) begin
      logic [31:0] exp_addr;
      i_bus_rdata = 32'hA5000000 + r;
      drive(tbl[r].rst, tbl[r].a, tbl[r].b, tbl[r].rdy);
      exp_addr = (tbl[r].grant == 2'b01) ? 32'h100 : (tbl[r].grant == 2'b10) ? 32'h2000 : 32'h0;
      chk32($sformatf("tbl%0d_grant", r), 32'(o_grant), 32'(tbl[r].grant));
      chk1($sformatf("tbl%0d_pa_ready", r), o_pa_ready, tbl[r].pa_rdy);
      chk1($sformatf("tbl%0d_pb_ready", r), o_pb_ready, tbl[r].pb_rdy);
      chk1($sformatf("tbl%0d_timeout", r), o_timeout, tbl[r].to);
      chk1($sformatf("tbl%0d_bus_req", r), o_bus_request, tbl[r].breq);
      chk32($sformatf("tbl%0d_bus_addr", r), o_bus_address, exp_addr);
      chk32($sformatf("tbl%0d_pa_rdata", r), o_pa_rdata, 32'hA5000000 + r);
      chk32($sformatf("tbl%0d_pb_rdata", r), o_pb_rdata, 32'hA5000000 + r);
      tick();
    end

    // Single A read, ready two cycles after grant
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    i_pa_rw = 1'b0; i_pa_address = 32'h100;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk32("rd_idle_grant", 32'(o_grant), 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk1("rd_g0_bus_req", o_bus_request, 1'b1);
    chk32("rd_g0_bus_addr", o_bus_address, 32'h100);
    chk1("rd_g0_pa_ready", o_pa_ready, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk1("rd_g1_pa_ready", o_pa_ready, 1'b0);
    tick();
    i_bus_rdata = 32'hDEADBEEF;
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk1("rd_g2_pa_ready", o_pa_ready, 1'b1);
    chk32("rd_g2_pa_rdata", o_pa_rdata, 32'hDEADBEEF);
    chk1("rd_g2_timeout", o_timeout, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk32("rd_after_grant", 32'(o_grant), 32'h0);
    chk1("rd_after_pa_ready", o_pa_ready, 1'b0);
    tick();

    // B write: bus carries B's fields, A never readied
    i_pb_rw = 1'b1; i_pb_address = 32'h2000; i_pb_wdata = 32'h12345678;
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    chk32("wr_grant", 32'(o_grant), 32'h2);
    chk1("wr_bus_rw", o_bus_rw, 1'b1);
    chk32("wr_bus_addr", o_bus_address, 32'h2000);
    chk32("wr_bus_wdata", o_bus_wdata, 32'h12345678);
    chk1("wr_g0_pa_ready", o_pa_ready, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk1("wr_pb_ready", o_pb_ready, 1'b1);
    chk1("wr_g1_pa_ready", o_pa_ready, 1'b0);
    chk32("wr_g1_bus_wdata", o_bus_wdata, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk32("wr_after_grant", 32'(o_grant), 32'h0);
    tick();

    // Reset in the middle of an A wait abandons the transaction
    drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk32("rst_pre_grant", 32'(o_grant), 32'h1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk1("rst_cycle_pa_ready", o_pa_ready, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    chk1("rst_post_pa_ready", o_pa_ready, 1'b0);
    chk32("rst_post_grant", 32'(o_grant), 32'h0);
    chk1("rst_post_bus_req", o_bus_request, 1'b0);
    chk32("rst_post_bus_addr", o_bus_address, 32'h0);
    chk1("rst_post_timeout", o_timeout, 1'b0);
    tick();

    // Random traffic; requesters hold their fields until ready (occasional abandon)
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    m_owner = 0; m_last = 1; m_wait = 0;
    model_step();
    tick();
    for (int n = 0; n < 3000; n++) begin
      i_reset = ($urandom_range(199) == 0);
      if (!i_pa_request) begin
        if ($urandom_range(2) == 0) begin
          i_pa_request = 1'b1; i_pa_rw = 1'($urandom);
          i_pa_address = $urandom; i_pa_wdata = $urandom;
        end
      end else if ($urandom_range(29) == 0) i_pa_request = 1'b0;
      if (!i_pb_request) begin
        if ($urandom_range(2) == 0) begin
          i_pb_request = 1'b1; i_pb_rw = 1'($urandom);
          i_pb_address = $urandom; i_pb_wdata = $urandom;
        end
      end else if ($urandom_range(29) == 0) i_pb_request = 1'b0;
      i_bus_ready = ($urandom_range(3) == 0);
      i_bus_rdata = $urandom;
      #1;
      model_step();
      tick();
      if (done_a) i_pa_request = 1'b0;
      if (done_b) i_pb_request = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the bus-wait cycles before a transaction is force-terminated; 0 disables the timeout.
REQ-002 SHALL have port i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_pa_request / i_pa_rw  in  1/1  port A (instruction fetch) request and write-enable.
REQ-005 SHALL have ports i_pa_address / i_pa_wdata  in  32/32  port A address and write data.
REQ-006 SHALL have ports o_pa_ready  out  1 and o_pa_rdata  out  32  port A completion strobe and read data.
REQ-007 SHALL have ports i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata, o_pb_ready and o_pb_rdata, identical to port A, for port B (memory stage).
REQ-008 SHALL have ports o_bus_request / o_bus_rw  out  1/1  shared bus request and write-enable.
REQ-009 SHALL have ports o_bus_address / o_bus_wdata  out  32/32  and i_bus_ready  in  1, i_bus_rdata  in  32  as the shared bus.
REQ-010 SHALL have ports o_timeout  out  1  one-cycle pulse on a forced termination, and o_grant  out  2  one-hot current owner ({B,A}).

Function
REQ-011 SHALL implement states IDLE, GRANT_A and GRANT_B, with a registered last_grant bit.
REQ-012 In IDLE with only one request high, the FSM SHALL enter that port's GRANT state next cycle.
REQ-013 In IDLE with both requests high, the FSM SHALL grant the port not equal to last_grant (round-robin) and update last_grant on grant entry.
REQ-014 In IDLE, o_bus_request SHALL be 0, o_bus_rw 0, o_bus_address 0, o_bus_wdata 0 and o_grant 0; i_bus_ready SHALL be ignored.
REQ-015 In GRANT_x, bus outputs SHALL combinationally carry port x's request, rw, address and wdata; o_grant SHALL be one-hot x.
REQ-016 o_px_ready SHALL be i_bus_ready AND state==GRANT_x AND i_px_request, combinationally; the non-granted port's ready SHALL be 0.
REQ-017 o_pa_rdata and o_pb_rdata SHALL both equal i_bus_rdata combinationally; validity is qualified only by ready.
REQ-018 On i_bus_ready in GRANT_x, the FSM SHALL return to IDLE next cycle.
REQ-019 Latency: a request first seen in cycle N SHALL give o_bus_request in N+1; back-to-back transactions SHALL have exactly one IDLE cycle between them.
REQ-020 If the granted port drops its request before ready, the FSM SHALL return to IDLE next cycle, with no ready and no timeout.
REQ-021 A 16-bit wait counter SHALL clear on grant entry and increment each GRANT cycle without i_bus_ready.
REQ-022 With TIMEOUT!=0 and wait counter==TIMEOUT, the arbiter SHALL, that same cycle: assert o_px_ready for the owner, pulse o_timeout, force o_bus_request 0, and go to IDLE next cycle.
REQ-023 i_bus_ready coinciding with the timeout cycle SHALL count as normal completion, so o_timeout is 0.
REQ-024 Write data is not buffered; requesters SHALL hold request, rw, address and wdata stable until ready, and the arbiter relies on this.

Reset
REQ-025 While i_reset is high at a clock edge, state SHALL be IDLE, last_grant A, wait counter 0.
REQ-026 Outputs SHALL then be: o_bus_* 0, o_p*_ready 0, o_timeout 0, o_grant 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no ready issued.
REQ-028 After reset, the first contended grant SHALL go to port B.

Verification
REQ-029 Single A read, addr 0x100, bus ready 2 cycles after grant, rdata 0xDEADBEEF -> o_pa_ready for 1 cycle with o_pa_rdata 0xDEADBEEF; FSM back to IDLE next cycle.
REQ-030 A and B requesting in the same cycle after reset -> B granted first; after B's ready and one IDLE cycle, A granted; o_grant sequence 10, 00, 01.
REQ-031 B write addr 0x2000 wdata 0x12345678 rw=1 -> bus shows those values while o_grant=10; o_pa_ready stays 0 throughout.
REQ-032 TIMEOUT=4, bus never ready -> at the 4th wait cycle, o_pb_ready=1 and o_timeout=1 for one cycle, o_bus_request=0; IDLE next cycle.
REQ-033 Reset asserted in GRANT_A mid-wait, then i_bus_ready=1 -> no o_pa_ready; all outputs 0 the cycle after the reset edge.
